dc_motor_pwm_multi: RTL and testbench

DC_MOTOR_PWM_MULTI -- requirements
Module: dc_motor_pwm_multi

---
 rtl/dc_motor_pwm_multi.sv | 240 ++++++++++++++++++++++++
 tb/tb_dc_motor_pwm_multi.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_motor_pwm_multi.sv
// -----------------------------------------------------------------------------
// dc_motor_pwm_multi
//   Multi-channel H-bridge DC motor driver. Each channel owns a PWM counter,
//   pending/active PERIOD and HIGH registers and a small IDLE/RUN/DEAD FSM that
//   inserts a coast window whenever the requested direction reverses.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   s_cs         slave select
//   s_address    {ch[2:0], reg[1:0]}  reg: 0 PERIOD, 1 HIGH, 2 CONTROL, 3 STATUS
//   s_write      write strobe (wins over s_read in the same cycle)
//   s_writedata  write data
//   s_read       read strobe
//   s_readdata   registered read data, valid the cycle after s_read
//   pwm[NUM_CH]  per-channel PWM enable
//   in1[NUM_CH]  per-channel bridge input 1
//   in2[NUM_CH]  per-channel bridge input 2
//
// CONTROL: bit0 go, bit1 forward, bit2 fast_decay
// STATUS : bit0 run, bit1 dead, bit2 active direction forward
// -----------------------------------------------------------------------------
module dc_motor_pwm_multi #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 32,
   parameter int DEAD_CYC = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_cs,
   input  logic [4:0]        s_address,
   input  logic              s_write,
   input  logic [31:0]       s_writedata,
   input  logic              s_read,
   output logic [31:0]       s_readdata,
   output logic [NUM_CH-1:0] pwm,
   output logic [NUM_CH-1:0] in1,
   output logic [NUM_CH-1:0] in2
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REG_PERIOD  = 2'd0,
      REG_HIGH    = 2'd1,
      REG_CONTROL = 2'd2,
      REG_STATUS  = 2'd3
   } reg_t;

   logic [2:0]  s_ch;
   reg_t        s_reg;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] ch_rdata [NUM_CH];
   logic [31:0] rd_mux;
   logic        unused_wdata;

   assign s_ch  = s_address[4:2];
   assign s_reg = reg_t'(s_address[1:0]);
   assign wr_en = s_cs & s_write;
   assign rd_en = s_cs & s_read & ~s_write;

   // Bits of the write bus above CNT_W and above the CONTROL field are dropped.
   assign unused_wdata = ^s_writedata;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic             sel;
      logic [CNT_W-1:0] period_pend;
      logic [CNT_W-1:0] high_pend;
      logic [CNT_W-1:0] period_act;
      logic [CNT_W-1:0] high_act;
      logic [CNT_W-1:0] cnt;
      logic             go;
      logic             forward;
      logic             fast_decay;
      logic             dir_act;
      logic [15:0]      dead_cnt;
      logic             wrap;
      logic             dead_done;
      logic             pwm_raw;
      state_t           state;
      state_t           state_nxt;
      logic [2:0]       drive_nxt;  // {in2, in1, pwm}
      logic [2:0]       drive_q;
      logic [31:0]      rdata;

      // Channel numbers with no hardware never match, so writes to them are
      // dropped and reads of them return 0.
      assign sel = (s_ch == 3'(i));

      // A zero period wraps every cycle: cnt stays 0 and pending values are
      // still picked up, so a stopped channel can be restarted by a write.
      assign wrap      = (period_act == '0) || (cnt == period_act - CNT_W'(1));
      assign dead_done = (dead_cnt == 16'd1);
      assign pwm_raw   = (period_act != '0) && (cnt < high_act);

      // Host-visible registers
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            period_pend <= '0;
            high_pend   <= '0;
            go          <= 1'b0;
            forward     <= 1'b0;
            fast_decay  <= 1'b1;
         end else if (wr_en && sel) begin
            case (s_reg)
               REG_PERIOD:  period_pend <= s_writedata[CNT_W-1:0];
               REG_HIGH:    high_pend   <= s_writedata[CNT_W-1:0];
               REG_CONTROL: begin
                  go         <= s_writedata[0];
                  forward    <= s_writedata[1];
                  fast_decay <= s_writedata[2];
               end
               default: ;  // STATUS is read-only
            endcase
         end
      end

      // FSM state register
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) state <= ST_IDLE;
         else          state <= state_nxt;
      end

      // FSM next state: go=0 always wins over a pending reversal
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      always_comb begin
         state_nxt = state;
         case (state)
            ST_IDLE: if (go) state_nxt = ST_RUN;
            ST_RUN: begin
               if (!go)                    state_nxt = ST_IDLE;
               else if (forward != dir_act) state_nxt = ST_DEAD;
            end
            ST_DEAD: begin
               if (!go)            state_nxt = ST_IDLE;
               else if (dead_done) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      // FSM output decode; registered below so outputs lag state by one cycle
      always_comb begin
         drive_nxt = 3'b000;
         case (state)
            ST_RUN:  drive_nxt = {dir_act, ~dir_act, pwm_raw};
            ST_IDLE: drive_nxt = fast_decay ? 3'b110 : 3'b000;
            default: drive_nxt = 3'b000;  // DEAD coasts
         endcase
      end

      // Counter, dead timer, active registers and output flops
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            period_act <= '0;
            high_act   <= '0;
            cnt        <= '0;
            dead_cnt   <= '0;
            dir_act    <= 1'b0;
            drive_q    <= 3'b110;
         end else begin
            drive_q <= drive_nxt;
            case (state)
               ST_IDLE: begin
                  cnt <= '0;
                  if (go) begin
                     period_act <= period_pend;
                     high_act   <= high_pend;
                     dir_act    <= forward;
                  end
               end
               ST_RUN: begin
                  if (!go) begin
                     cnt <= '0;
                  end else if (forward != dir_act) begin
                     dead_cnt <= 16'(DEAD_CYC);
                  end else if (wrap) begin
                     cnt        <= '0;
                     period_act <= period_pend;
                     high_act   <= high_pend;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_DEAD: begin
                  // Direction is sampled only at exit, so toggling forward
                  // inside the window never restarts the timer.
                  if (!go) begin
                     cnt <= '0;
                  end else if (dead_done) begin
                     cnt     <= '0;
                     dir_act <= forward;
                  end else begin
                     dead_cnt <= dead_cnt - 16'd1;
                  end
               end
               default: cnt <= '0;
            endcase
         end
      end

      // Read-back; PERIOD/HIGH show the pending (last written) value
      always_comb begin
         rdata = '0;
         if (sel) begin
            case (s_reg)
               REG_PERIOD:  rdata = 32'(period_pend);
               REG_HIGH:    rdata = 32'(high_pend);
               REG_CONTROL: rdata = {29'd0, fast_decay, forward, go};
               default:     rdata = {29'd0, dir_act, (state == ST_DEAD), (state == ST_RUN)};
            endcase
         end
      end

      assign ch_rdata[i] = rdata;
      assign pwm[i]      = drive_q[0];
      assign in1[i]      = drive_q[1];
      assign in2[i]      = drive_q[2];
   end

   // At most one channel is selected, the rest contribute zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) rd_mux = rd_mux | ch_rdata[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   s_readdata <= '0;
      else if (rd_en) s_readdata <= rd_mux;
   end

endmodule

// File: tb/tb_dc_motor_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_dc_motor_pwm_multi
//   Self-checking bench for dc_motor_pwm_multi (NUM_CH=2, CNT_W=32,
//   DEAD_CYC=16). Expected waveforms come from closed-form rules: a channel
//   started k samples ago shows pwm = (k mod PERIOD) < HIGH, with the bridge
//   pattern fixed by direction; dead windows are DEAD_CYC samples of coast.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dc_motor_pwm_multi;

   localparam int NUM_CH   = 2;
   localparam int CNT_W    = 32;
   localparam int DEAD_CYC = 16;

   localparam logic [1:0] R_PERIOD = 2'd0;
   localparam logic [1:0] R_HIGH   = 2'd1;
   localparam logic [1:0] R_CTRL   = 2'd2;
   localparam logic [1:0] R_STATUS = 2'd3;

   localparam logic [3*NUM_CH-1:0] RST_OUT = {{NUM_CH{1'b1}}, {NUM_CH{1'b1}}, {NUM_CH{1'b0}}};

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              s_cs = 1'b0;
   logic [4:0]        s_address = '0;
   logic              s_write = 1'b0;
   logic [31:0]       s_writedata = '0;
   logic              s_read = 1'b0;
   logic [31:0]       s_readdata;
   logic [NUM_CH-1:0] pwm;
   logic [NUM_CH-1:0] in1;
   logic [NUM_CH-1:0] in2;

   int n_pass  = 0;
   int n_total = 0;

   // Values shared between the independence and bus tests
   int p0, h0, p1, h1;
   bit fwd0, fwd1;

   dc_motor_pwm_multi #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEAD_CYC(DEAD_CYC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .s_cs       (s_cs),
      .s_address  (s_address),
      .s_write    (s_write),
      .s_writedata(s_writedata),
      .s_read     (s_read),
      .s_readdata (s_readdata),
      .pwm        (pwm),
      .in1        (in1),
      .in2        (in2)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------- helpers
   function automatic logic [2:0] drv(input int ch);
      return {in2[ch], in1[ch], pwm[ch]};
   endfunction

   // Reference: sample k of a running channel
   function automatic logic [2:0] exp_run(input int k, input int p, input int h, input bit fwd);
      logic raw;
      raw = 1'b0;
      if (p != 0) raw = ((k % p) < h);
      return {fwd, ~fwd, raw};
   endfunction

   function automatic logic [31:0] ctl(input bit go, input bit fwd, input bit fd);
      return {29'd0, fd, fwd, go};
   endfunction

   task automatic bus_write(input int ch, input logic [1:0] r, input logic [31:0] d);
      @(negedge clk);
      s_cs = 1'b1; s_write = 1'b1; s_address = {3'(ch), r}; s_writedata = d;
      @(negedge clk);
      s_cs = 1'b0; s_write = 1'b0;
   endtask

   task automatic bus_read(input int ch, input logic [1:0] r, output logic [31:0] d);
      @(negedge clk);
      s_cs = 1'b1; s_read = 1'b1; s_address = {3'(ch), r};
      @(negedge clk);
      s_cs = 1'b0; s_read = 1'b0;
      d = s_readdata;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      logic [31:0] d;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({in2, in1, pwm} !== RST_OUT)
         $display("FAIL reset_outputs: got %b expected %b", {in2, in1, pwm}, RST_OUT);
      else n_pass++;
      n_total++;
      if (s_readdata !== 32'd0) $display("FAIL reset_readdata: got %h expected 0", s_readdata);
      else n_pass++;
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(0, R_CTRL, d);
      n_total++;
      if (d !== 32'h4) $display("FAIL reset_ctrl: got %h expected 4", d); else n_pass++;
      bus_read(1, R_PERIOD, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL reset_period: got %h expected 0", d); else n_pass++;
      bus_read(0, R_STATUS, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL reset_status: got %h expected 0", d); else n_pass++;
   endtask

   // Directed corner cases first, then random PERIOD/HIGH/direction
   task automatic test_duty();
      for (int i = 0; i < 8; i++) begin
         int p, h, n;
         bit fwd;
         logic [2:0] e;
         case (i)
            0: begin p = 10; h = 4;  end
            1: begin p = 7;  h = 0;  end
            2: begin p = 6;  h = 6;  end
            3: begin p = 8;  h = 20; end
            4: begin p = 0;  h = 3;  end
            default: begin
               p = int'($urandom_range(2, 20));
               h = int'($urandom_range(0, p + 2));
            end
         endcase
         fwd = (i == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         n = 2 * ((p > 0) ? p : 1) + 2;
         bus_write(0, R_PERIOD, 32'(p));
         bus_write(0, R_HIGH, 32'(h));
         bus_write(0, R_CTRL, ctl(1'b1, fwd, 1'b0));
         @(negedge clk);
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = exp_run(k, p, h, fwd);
            n_total++;
            if (drv(0) !== e)
               $display("FAIL duty[%0d] P=%0d H=%0d k=%0d: got %b expected %b", i, p, h, k, drv(0), e);
            else n_pass++;
         end
         n_total++;
         if (drv(1) !== 3'b110) $display("FAIL duty_ch1_idle[%0d]: got %b expected 110", i, drv(1));
         else n_pass++;
         bus_write(0, R_CTRL, ctl(1'b0, 1'b0, 1'b0));
         repeat (2) @(negedge clk);
         n_total++;
         if (drv(0) !== 3'b000) $display("FAIL duty_stop[%0d]: got %b expected 000", i, drv(0));
         else n_pass++;
      end
   endtask

   // HIGH rewritten mid-period takes effect only from the next period
   task automatic test_high_update();
      logic [2:0] e;
      bus_write(0, R_PERIOD, 32'd10);
      bus_write(0, R_HIGH, 32'd4);
      bus_write(0, R_CTRL, ctl(1'b1, 1'b1, 1'b0));
      @(negedge clk);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         s_cs = 1'b0; s_write = 1'b0; s_read = 1'b0;
         e = exp_run(k, 10, (k < 10) ? 4 : 7, 1'b1);
         n_total++;
         if (drv(0) !== e) $display("FAIL high_update k=%0d: got %b expected %b", k, drv(0), e);
         else n_pass++;
         if (k == 4) begin
            n_total++;
            if (s_readdata !== 32'd7) $display("FAIL high_readback: got %h expected 7", s_readdata);
            else n_pass++;
         end
         if (k == 2) begin
            s_cs = 1'b1; s_write = 1'b1; s_address = {3'd0, R_HIGH}; s_writedata = 32'd7;
         end
         if (k == 3) begin
            s_cs = 1'b1; s_read = 1'b1; s_address = {3'd0, R_HIGH};
         end
      end
      bus_write(0, R_CTRL, ctl(1'b0, 1'b0, 1'b0));
   endtask

   task automatic test_reversal();
      logic [31:0] d;
      logic [2:0]  e;
      int h;
      h = int'($urandom_range(1, 9));
      bus_write(0, R_PERIOD, 32'd10);
      bus_write(0, R_HIGH, 32'(h));
      bus_write(0, R_CTRL, ctl(1'b1, 1'b1, 1'b0));
      repeat (13) @(negedge clk);
      bus_read(0, R_STATUS, d);
      n_total++;
      if (d !== 32'h5) $display("FAIL status_run_fwd: got %h expected 5", d); else n_pass++;

      // Forward -> reverse
      bus_write(0, R_CTRL, ctl(1'b1, 1'b0, 1'b0));
      @(negedge clk);
      for (int k = 0; k < DEAD_CYC; k++) begin
         @(negedge clk);
         n_total++;
         if (drv(0) !== 3'b000) $display("FAIL dead_rev k=%0d: got %b expected 000", k, drv(0));
         else n_pass++;
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         e = exp_run(k, 10, h, 1'b0);
         n_total++;
         if (drv(0) !== e) $display("FAIL run_rev k=%0d: got %b expected %b", k, drv(0), e);
         else n_pass++;
      end
      bus_read(0, R_STATUS, d);
      n_total++;
      if (d !== 32'h1) $display("FAIL status_run_rev: got %h expected 1", d); else n_pass++;

      // Reverse -> forward, with forward toggled back and forth inside the window
      bus_write(0, R_CTRL, ctl(1'b1, 1'b1, 1'b0));
      bus_read(0, R_STATUS, d);
      n_total++;
      if (d !== 32'h2) $display("FAIL status_dead: got %h expected 2", d); else n_pass++;
      bus_write(0, R_CTRL, ctl(1'b1, 1'b0, 1'b0));
      bus_write(0, R_CTRL, ctl(1'b1, 1'b1, 1'b0));
      for (int k = 7; k <= DEAD_CYC + 1; k++) begin
         @(negedge clk);
         n_total++;
         if (drv(0) !== 3'b000) $display("FAIL dead_toggle k=%0d: got %b expected 000", k, drv(0));
         else n_pass++;
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         e = exp_run(k, 10, h, 1'b1);
         n_total++;
         if (drv(0) !== e) $display("FAIL run_fwd_after_dead k=%0d: got %b expected %b", k, drv(0), e);
         else n_pass++;
      end
   endtask

   // Stop while running forward: go=0 wins over the simultaneous reversal
   task automatic test_idle_modes();
      bus_write(0, R_CTRL, ctl(1'b0, 1'b0, 1'b1));
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (drv(0) !== 3'b110) $display("FAIL idle_fast k=%0d: got %b expected 110", k, drv(0));
         else n_pass++;
         @(negedge clk);
      end
      bus_write(0, R_CTRL, ctl(1'b0, 1'b0, 1'b0));
      repeat (2) @(negedge clk);
      n_total++;
      if (drv(0) !== 3'b000) $display("FAIL idle_slow: got %b expected 000", drv(0));
      else n_pass++;
   endtask

   task automatic test_independent();
      logic [2:0] e;
      p0 = int'($urandom_range(3, 15));
      h0 = int'($urandom_range(0, p0 - 1));
      p1 = int'($urandom_range(2, 15));
      h1 = int'($urandom_range(0, p1 + 1));
      fwd0 = ($urandom_range(0, 1) == 1);
      fwd1 = ($urandom_range(0, 1) == 1);
      bus_write(0, R_PERIOD, 32'(p0));
      bus_write(0, R_HIGH, 32'(h0));
      bus_write(1, R_PERIOD, 32'(p1));
      bus_write(1, R_HIGH, 32'(h1));
      bus_write(0, R_CTRL, ctl(1'b1, fwd0, 1'b0));
      bus_write(1, R_CTRL, ctl(1'b1, fwd1, 1'b0));
      // Channel 1 starts two cycles after channel 0
      for (int k = 2; k < 42; k++) begin
         e = exp_run(k - 2, p0, h0, fwd0);
         n_total++;
         if (drv(0) !== e) $display("FAIL indep_ch0 k=%0d: got %b expected %b", k, drv(0), e);
         else n_pass++;
         if (k >= 4) begin
            e = exp_run(k - 4, p1, h1, fwd1);
            n_total++;
            if (drv(1) !== e) $display("FAIL indep_ch1 k=%0d: got %b expected %b", k, drv(1), e);
            else n_pass++;
         end
         @(negedge clk);
      end
      bus_write(0, R_CTRL, ctl(1'b0, 1'b0, 1'b1));
      bus_write(1, R_CTRL, ctl(1'b0, 1'b0, 1'b1));
   endtask

   task automatic test_bus_misc();
      logic [31:0] d;
      bus_read(0, R_PERIOD, d);
      n_total++;
      if (d !== 32'(p0)) $display("FAIL read_period: got %h expected %h", d, 32'(p0)); else n_pass++;
      bus_read(5, R_PERIOD, d);
      n_total++;
      if (d !== 32'd0) $display("FAIL read_bad_ch: got %h expected 0", d); else n_pass++;

      bus_write(0, R_STATUS, 32'hFFFF_FFFF);
      bus_read(0, R_STATUS, d);
      n_total++;
      if (d !== {29'd0, fwd0, 2'b00}) $display("FAIL status_wr_ignored: got %h expected %h", d, {29'd0, fwd0, 2'b00});
      else n_pass++;
      bus_read(0, R_CTRL, d);
      n_total++;
      if (d !== 32'h4) $display("FAIL ctrl_after_status_wr: got %h expected 4", d); else n_pass++;

      bus_write(5, R_PERIOD, 32'h55);
      bus_read(1, R_PERIOD, d);
      n_total++;
      if (d !== 32'(p1)) $display("FAIL bad_ch_write: got %h expected %h", d, 32'(p1)); else n_pass++;

      // Write and read in the same cycle: write lands, read data holds
      bus_read(0, R_HIGH, d);
      @(negedge clk);
      s_cs = 1'b1; s_write = 1'b1; s_read = 1'b1; s_address = {3'd0, R_PERIOD}; s_writedata = 32'h1234;
      @(negedge clk);
      s_cs = 1'b0; s_write = 1'b0; s_read = 1'b0;
      n_total++;
      if (s_readdata !== 32'(h0)) $display("FAIL wr_rd_hold: got %h expected %h", s_readdata, 32'(h0));
      else n_pass++;
      bus_read(0, R_PERIOD, d);
      n_total++;
      if (d !== 32'h1234) $display("FAIL wr_rd_write: got %h expected 1234", d); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      // Reset while channel 0 is in its dead window
      bus_write(0, R_PERIOD, 32'd10);
      bus_write(0, R_HIGH, 32'd4);
      bus_write(0, R_CTRL, ctl(1'b1, 1'b1, 1'b0));
      repeat (5) @(negedge clk);
      bus_read(0, R_PERIOD, d);
      n_total++;
      if (d !== 32'd10) $display("FAIL pre_reset_read: got %h expected a", d); else n_pass++;
      bus_write(0, R_CTRL, ctl(1'b1, 1'b0, 1'b0));
      repeat (4) @(negedge clk);
      n_total++;
      if (drv(0) !== 3'b000) $display("FAIL pre_reset_dead: got %b expected 000", drv(0)); else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if ({in2, in1, pwm} !== RST_OUT)
         $display("FAIL reset_in_dead: got %b expected %b", {in2, in1, pwm}, RST_OUT);
      else n_pass++;
      n_total++;
      if (s_readdata !== 32'd0) $display("FAIL reset_in_dead_rd: got %h expected 0", s_readdata); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(0, R_CTRL, d);
      n_total++;
      if (d !== 32'h4) $display("FAIL post_reset_ctrl: got %h expected 4", d); else n_pass++;
      bus_read(0, R_HIGH, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL post_reset_high: got %h expected 0", d); else n_pass++;
      bus_read(0, R_STATUS, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL post_reset_status: got %h expected 0", d); else n_pass++;

      // Reset while channel 1 runs at 100% duty
      bus_write(1, R_PERIOD, 32'd6);
      bus_write(1, R_HIGH, 32'd6);
      bus_write(1, R_CTRL, ctl(1'b1, 1'b1, 1'b0));
      repeat (4) @(negedge clk);
      n_total++;
      if (drv(1) !== 3'b101) $display("FAIL pre_reset_run: got %b expected 101", drv(1)); else n_pass++;
      bus_read(1, R_HIGH, d);
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if ({in2, in1, pwm} !== RST_OUT)
         $display("FAIL reset_in_run: got %b expected %b", {in2, in1, pwm}, RST_OUT);
      else n_pass++;
      n_total++;
      if (s_readdata !== 32'd0) $display("FAIL reset_in_run_rd: got %h expected 0", s_readdata); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_duty();
      test_high_update();
      test_reversal();
      test_idle_modes();
      test_independent();
      test_bus_misc();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
